slavefifo_pkt_gen: RTL and testbench
====================================

# slavefifo_pkt_gen

Parametrised packet generator for the FX3 slave-FIFO write path, successor to the fixed-strobe ZLP generator. Writes packets of run-time-selectable length (0 = zero-length packet) into the FX3 DMA buffer, marks short packets with pktend_ on the last word, and can append a ZLP after full-buffer packets. Sits beside the stream and loopback generators behind the slave-FIFO mode mux, driving slwr_, pktend_ and the data bus.

## Interface
- DATA_W, 32: data bus width.
- LEN_W, 11: width of pkt_len; must satisfy 2^LEN_W > BUF_WORDS.
- BUF_WORDS, 1024: FX3 buffer size in words; a packet of this length is a full packet.
- GAP_CYCLES, 16: idle cycles inserted after every packet (>= 1).

Ports:
- clk_100  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  mode selected; low returns the block to IDLE and clears data.
- pkt_len  in  LEN_W  requested packet length in words, sampled at packet start.
- append_zlp  in  1  send a ZLP after each full packet, sampled at packet start.
- flaga_d  in  1  registered FX3 FLAGA (buffer available).
- flagb_d  in  1  registered FX3 FLAGB (watermark not reached; write allowed).
- slwr_  out  1  active-low write strobe.
- pktend_  out  1  active-low packet end.
- data_out  out  DATA_W  write data, incrementing pattern.
- pkt_count  out  16  completed packets (ZLPs included), wraps.
- busy  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, WAIT_FLAG, WRITE, ZLP, GAP.
- IDLE: if enable && flaga_d, latch len_q = min(pkt_len, BUF_WORDS), zlp_q = append_zlp, clear word counter; go WAIT_FLAG.
- WAIT_FLAG: on flagb_d, go ZLP if len_q == 0, else WRITE.
- WRITE: slwr_ low in every cycle with flagb_d high; flagb_d low stalls (slwr_ high, counters hold, stay in WRITE). Last word = write cycle with word_cnt == len_q-1.
  - Short packet (len_q < BUF_WORDS): pktend_ low together with slwr_ on the last word; go GAP.
  - Full packet: no pktend_; go ZLP if zlp_q, else GAP.
- ZLP: if flagb_d, pktend_ low for exactly one cycle with slwr_ high, then go GAP; else wait.
- GAP: count GAP_CYCLES cycles, then IDLE.
- pkt_count increments once per packet: on the last-word cycle of a short packet, on the last-word cycle of a full packet, and on the ZLP pktend_ cycle (so a full packet plus ZLP counts 2).
- data_out increments by 1 (mod 2^DATA_W) on every cycle slwr_ is low; cleared to 0 whenever enable is low.
- enable falling mid-packet: next state IDLE, strobes high from the following edge; no pktend_ issued for the truncated packet.

## Timing
- Reset (sync): state IDLE, counters 0; from the first rising edge with reset high: slwr_=1, pktend_=1, data_out=0, pkt_count=0, busy=0.
- slwr_ and pktend_ are combinational decodes of registered state, registered word counter and flagb_d: zero latency from flagb_d.
- data_out is registered: word N of the stream is presented while slwr_ is low and advances on that edge.
- Earliest first write: 2 cycles after flaga_d seen high in IDLE (IDLE -> WAIT_FLAG -> WRITE with flagb_d high).
- Minimum packet period for length L, no stalls: 1 + 1 + L + GAP_CYCLES cycles.
- pkt_len/append_zlp changes during a packet take effect at the next packet.
- pkt_len > BUF_WORDS clamps to BUF_WORDS (full packet).

## Structure
- Package slavefifo_pkg: state enum (shared with sibling generators) and default parameter constants.
- Sub-module slavefifo_data_gen: DATA_W incrementing counter with increment and synchronous clear inputs; reused by stream/loopback generators.
- Word counter, gap counter and FSM stay in this module.

## Test plan
- pkt_len=4, flags high -> 4 slwr_ lows, data 0..3, pktend_ low with word 3, pkt_count=1, 16 idle cycles before next WAIT_FLAG.
- pkt_len=0 -> no slwr_, single one-cycle pktend_ in ZLP state, pkt_count increments by 1, data_out stays 0.
- pkt_len=1024, append_zlp=1 -> 1024 writes without pktend_, then one standalone pktend_; pkt_count +2. With append_zlp=0 -> no pktend_, +1.
- pkt_len=8, flagb_d low for 3 cycles after word 2 -> slwr_ high 3 cycles, data holds at 3, resumes; pktend_ on word 7.
- enable dropped after word 5 of a 10-word packet -> no pktend_, state IDLE, data_out=0 next cycle; reset asserted mid-write -> all outputs inactive from that edge.

Source files
------------

// File: rtl/slavefifo_pkg.sv
// Shared definitions for the FX3 slave-FIFO generators: the common state
// encoding and the default parameter values.
package slavefifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FLAG,
    ST_WRITE,
    ST_ZLP,
    ST_GAP
  } slavefifo_state_e;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LEN_W      = 11;
  localparam int DEF_BUF_WORDS  = 1024;
  localparam int DEF_GAP_CYCLES = 16;

endpackage

// File: rtl/slavefifo_data_gen.sv
// Incrementing data-pattern counter for the slave-FIFO generators.
// Synchronous clear has priority over the increment.
module slavefifo_data_gen #(
  parameter int DATA_W = 32
) (
  input  logic              clk_100,
  input  logic              reset,
  input  logic              clear,
  input  logic              incr,
  output logic [DATA_W-1:0] data
);

  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk_100) begin
    if (reset || clear) begin
      data <= '0;
    end else if (incr) begin
      data <= data + DATA_W'(1);
    end
  end

endmodule

// File: rtl/slavefifo_pkt_gen.sv
// FX3 slave-FIFO packet generator: writes packets of selectable length,
// terminates short packets with pktend_, optionally follows full packets with a ZLP.
module slavefifo_pkt_gen
  import slavefifo_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int BUF_WORDS  = DEF_BUF_WORDS,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic              clk_100,
  input  logic              reset,
  input  logic              enable,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic              append_zlp,
  input  logic              flaga_d,
  input  logic              flagb_d,
  output logic              slwr_,
  output logic              pktend_,
  output logic [DATA_W-1:0] data_out,
  output logic [15:0]       pkt_count,
  output logic              busy
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(BUF_WORDS);

  slavefifo_state_e state, state_nxt;

  logic [LEN_W-1:0] len_q;
  logic             zlp_q;
  logic [LEN_W-1:0] word_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic             start;
  logic             write_en;
  logic             last_word;
  logic             full_pkt;
  logic             zlp_fire;
  logic             gap_done;
  logic [LEN_W-1:0] len_clamped;

  assign start       = enable && flaga_d;
  assign len_clamped = (pkt_len > FULL_LEN) ? FULL_LEN : pkt_len;
  assign full_pkt    = (len_q == FULL_LEN);

  // Strobes decode straight from state and flagb_d so a stall costs no cycle.
  assign write_en  = (state == ST_WRITE) && flagb_d;
  assign last_word = write_en && (word_cnt == len_q - LEN_W'(1));
  assign zlp_fire  = (state == ST_ZLP) && flagb_d;
  assign gap_done  = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  assign slwr_   = !write_en;
  assign pktend_ = !((last_word && !full_pkt) || zlp_fire);
  assign busy    = (state != ST_IDLE);

  // NOTE: every output of this block gets a default first, so no path can
  // leave state_nxt unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start) state_nxt = ST_WAIT_FLAG;
      ST_WAIT_FLAG: if (flagb_d) state_nxt = (len_q == '0) ? ST_ZLP : ST_WRITE;
      ST_WRITE: begin
        if (last_word) begin
          state_nxt = (full_pkt && zlp_q) ? ST_ZLP : ST_GAP;
        end
      end
      ST_ZLP:       if (flagb_d) state_nxt = ST_GAP;
      ST_GAP:       if (gap_done) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
    if (!enable) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk_100) begin
    if (reset) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      zlp_q     <= 1'b0;
      word_cnt  <= '0;
      gap_cnt   <= '0;
      pkt_count <= '0;
    end else begin
      state <= state_nxt;

      if (state == ST_IDLE && start) begin
        len_q    <= len_clamped;
        zlp_q    <= append_zlp;
        word_cnt <= '0;
      end else if (write_en) begin
        word_cnt <= word_cnt + LEN_W'(1);
      end

      gap_cnt <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;

      if (last_word || zlp_fire) begin
        pkt_count <= pkt_count + 16'd1;
      end
    end
  end

  slavefifo_data_gen #(
    .DATA_W (DATA_W)
  ) u_data_gen (
    .clk_100 (clk_100),
    .reset   (reset),
    .clear   (!enable),
    .incr    (write_en),
    .data    (data_out)
  );

endmodule

// File: tb/tb_slavefifo_pkt_gen.sv
// Directed bench for slavefifo_pkt_gen: short, zero-length, full and clamped
// packets, flagb_d stalls, enable drop and reset mid-packet.
module tb_slavefifo_pkt_gen;

  logic        clk_100 = 1'b0;
  logic        reset;
  logic        enable;
  logic [10:0] pkt_len;
  logic        append_zlp;
  logic        flaga_d;
  logic        flagb_d;
  logic        slwr_;
  logic        pktend_;
  logic [31:0] data_out;
  logic [15:0] pkt_count;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_100 = ~clk_100;

  slavefifo_pkt_gen dut (
    .clk_100    (clk_100),
    .reset      (reset),
    .enable     (enable),
    .pkt_len    (pkt_len),
    .append_zlp (append_zlp),
    .flaga_d    (flaga_d),
    .flagb_d    (flagb_d),
    .slwr_      (slwr_),
    .pktend_    (pktend_),
    .data_out   (data_out),
    .pkt_count  (pkt_count),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the edge; outputs are sampled 1 later.
  task automatic cyc();
    @(posedge clk_100);
    #2;
  endtask

  task automatic start_pkt(input logic [10:0] len, input logic zlp);
    pkt_len    = len;
    append_zlp = zlp;
    enable     = 1'b1;
    flaga_d    = 1'b1;
    flagb_d    = 1'b1;
    cyc();
    #1;
    check("wait_flag_busy", 32'(busy), 32'd1);
    check("wait_flag_slwr", 32'(slwr_), 32'd1);
    cyc();
    #1;
  endtask

  task automatic stop_pkt(input string tag);
    enable = 1'b0;
    cyc();
    #1;
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_data"}, data_out, 32'd0);
  endtask

  initial begin
    int n;
    int writes;
    int ends;
    int data_errs;

    reset      = 1'b1;
    enable     = 1'b0;
    pkt_len    = '0;
    append_zlp = 1'b0;
    flaga_d    = 1'b0;
    flagb_d    = 1'b0;
    cyc();
    #1;
    check("rst_slwr", 32'(slwr_), 32'd1);
    check("rst_pktend", 32'(pktend_), 32'd1);
    check("rst_data", data_out, 32'd0);
    check("rst_count", 32'(pkt_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    cyc();

    // Short packet of 4 words.
    start_pkt(11'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("p4_slwr_w%0d", i), 32'(slwr_), 32'd0);
      check($sformatf("p4_data_w%0d", i), data_out, 32'(i));
      check($sformatf("p4_pktend_w%0d", i), 32'(pktend_), (i == 3) ? 32'd0 : 32'd1);
      cyc();
    end
    check("p4_count", 32'(pkt_count), 32'd1);
    check("p4_data_after", data_out, 32'd4);
    check("p4_gap_slwr", 32'(slwr_), 32'd1);
    n = 0;
    while (busy && n < 40) begin
      n++;
      cyc();
    end
    check("p4_gap_cycles", 32'(n), 32'd16);
    cyc();
    check("p4_rearm_busy", 32'(busy), 32'd1);
    stop_pkt("p4");

    // Zero-length packet.
    start_pkt(11'd0, 1'b0);
    check("zlp0_pktend", 32'(pktend_), 32'd0);
    check("zlp0_slwr", 32'(slwr_), 32'd1);
    cyc();
    check("zlp0_pktend_after", 32'(pktend_), 32'd1);
    check("zlp0_count", 32'(pkt_count), 32'd2);
    check("zlp0_data", data_out, 32'd0);
    stop_pkt("zlp0");

    // Full packet followed by a ZLP, with a flagb_d wait inside the ZLP state.
    start_pkt(11'd1024, 1'b1);
    writes = 0; ends = 0; data_errs = 0;
    for (int i = 0; i < 1024; i++) begin
      if (!slwr_) writes++;
      if (!pktend_) ends++;
      if (data_out !== 32'(i)) data_errs++;
      cyc();
    end
    check("full_writes", 32'(writes), 32'd1024);
    check("full_pktends", 32'(ends), 32'd0);
    check("full_data_errs", 32'(data_errs), 32'd0);
    check("full_count", 32'(pkt_count), 32'd3);
    flagb_d = 1'b0;
    #1;
    check("full_zlp_wait_pktend", 32'(pktend_), 32'd1);
    cyc();
    flagb_d = 1'b1;
    #1;
    check("full_zlp_pktend", 32'(pktend_), 32'd0);
    check("full_zlp_slwr", 32'(slwr_), 32'd1);
    cyc();
    check("full_zlp_count", 32'(pkt_count), 32'd4);
    check("full_zlp_pktend_after", 32'(pktend_), 32'd1);
    stop_pkt("full_zlp");

    // Oversized length clamps to a full packet; no ZLP requested.
    start_pkt(11'd1500, 1'b0);
    writes = 0; ends = 0;
    for (int i = 0; i < 1024; i++) begin
      if (!slwr_) writes++;
      if (!pktend_) ends++;
      cyc();
    end
    check("clamp_writes", 32'(writes), 32'd1024);
    check("clamp_pktends", 32'(ends), 32'd0);
    check("clamp_count", 32'(pkt_count), 32'd5);
    check("clamp_gap_slwr", 32'(slwr_), 32'd1);
    check("clamp_gap_pktend", 32'(pktend_), 32'd1);
    stop_pkt("clamp");

    // 8-word packet stalled for 3 cycles after word 2; pkt_len changes mid-packet.
    start_pkt(11'd8, 1'b0);
    pkt_len = 11'd2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall_data_w%0d", i), data_out, 32'(i));
      check($sformatf("stall_slwr_w%0d", i), 32'(slwr_), 32'd0);
      cyc();
    end
    flagb_d = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall_hold_slwr%0d", k), 32'(slwr_), 32'd1);
      check($sformatf("stall_hold_data%0d", k), data_out, 32'd3);
      cyc();
    end
    flagb_d = 1'b1;
    #1;
    for (int i = 3; i < 8; i++) begin
      check($sformatf("stall_data_w%0d", i), data_out, 32'(i));
      check($sformatf("stall_pktend_w%0d", i), 32'(pktend_), (i == 7) ? 32'd0 : 32'd1);
      cyc();
    end
    check("stall_count", 32'(pkt_count), 32'd6);
    stop_pkt("stall");

    // Enable drops after word 5 of a 10-word packet.
    start_pkt(11'd10, 1'b0);
    for (int i = 0; i < 6; i++) cyc();
    check("abort_data_w6", data_out, 32'd6);
    enable = 1'b0;
    #1;
    check("abort_pktend", 32'(pktend_), 32'd1);
    cyc();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_slwr", 32'(slwr_), 32'd1);
    check("abort_data", data_out, 32'd0);
    check("abort_count", 32'(pkt_count), 32'd6);

    // Reset asserted mid-write.
    start_pkt(11'd10, 1'b0);
    cyc();
    cyc();
    cyc();
    check("rstmid_data_before", data_out, 32'd3);
    reset = 1'b1;
    cyc();
    #1;
    check("rstmid_slwr", 32'(slwr_), 32'd1);
    check("rstmid_pktend", 32'(pktend_), 32'd1);
    check("rstmid_data", data_out, 32'd0);
    check("rstmid_count", 32'(pkt_count), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    reset  = 1'b0;
    enable = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
